detector_arbiter_ctrl: RTL and testbench

//  Sequencing controller and arbiter for the 2-bit serial detector FSM (X in, Y out).
//  Two requesters each present a WIDTH-bit word. The block grants the detector to one of them
//  and clears the detector before each frame. It shifts the word MSB-first onto X, counts Y

---
 rtl/detector_arbiter_ctrl.sv | 144 ++++++++++++++
 tb/tb_detector_arbiter_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/detector_arbiter_ctrl.sv
// detector_arbiter_ctrl
//   Grants a 2-bit serial detector to one of two requesters, clears it, shifts the
//   captured word MSB-first onto X and counts the Y samples that read high.
//   Compile-time option: define RR_ARB_EN for round-robin tie-breaking; otherwise
//   requester 0 wins every tie.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no grant; arbitrate pending requests, capture winning word
//   CLEAR  | detector held in reset, hit count zeroed
//   SHIFT  | WIDTH cycles driving the word MSB-first on X, sampling Y
//   DRAIN  | X low, last Y sample (detector output lags X by one cycle)
//   REPORT | DONE pulse, HITS valid, grant still held
module detector_arbiter_ctrl #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DATA0,
  input  logic [WIDTH-1:0] DATA1,
  input  logic             Y,
  output logic             GNT0,
  output logic             GNT1,
  output logic             X,
  output logic             DET_RESET,
  output logic             DONE,
  output logic [CW-1:0]    HITS,
  output logic             OWNER
);

  localparam int CNTW = $clog2(WIDTH);

  typedef enum logic [2:0] {IDLE, CLEAR, SHIFT, DRAIN, REPORT} stateT;

  stateT            state, nextState;
  logic [WIDTH-1:0] shiftReg;
  logic [CNTW-1:0]  bitCnt;
  logic [CW-1:0]    hitCnt;
  logic [CW-1:0]    hitsReg;
  logic             ownerReg;
  logic             anyReq;
  logic             grantSel;
  logic             lastBit;
  logic             firstBit;
  logic             gntActive;
  logic             xOut;
  logic             clearPhase;
  logic             doneOut;

  assign anyReq   = REQ0 | REQ1;
  // bitCnt runs down from WIDTH-1; the first SHIFT cycle has no valid Y yet
  assign lastBit  = (bitCnt == '0);
  assign firstBit = (bitCnt == CNTW'(WIDTH - 1));

`ifdef RR_ARB_EN
  // tie goes to whoever did not hold the detector last
  assign grantSel = (REQ0 & REQ1) ? ~ownerReg : REQ1;
`else
  // requester 0 always wins a tie
  assign grantSel = ~REQ0;
`endif

  // state register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= nextState;
  end

  // next-state and Moore outputs
  always_comb begin
    nextState  = state;
    gntActive  = 1'b0;
    xOut       = 1'b0;
    clearPhase = 1'b0;
    doneOut    = 1'b0;
    case (state)
      IDLE:   if (anyReq) nextState = CLEAR;
      CLEAR: begin
        gntActive  = 1'b1;
        clearPhase = 1'b1;
        nextState  = SHIFT;
      end
      SHIFT: begin
        gntActive = 1'b1;
        xOut      = shiftReg[WIDTH-1];
        if (lastBit) nextState = DRAIN;
      end
      DRAIN: begin
        gntActive = 1'b1;
        nextState = REPORT;
      end
      REPORT: begin
        gntActive = 1'b1;
        doneOut   = 1'b1;
        nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  // capture, shift, bit timer and hit counting
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      shiftReg <= '0;
      bitCnt   <= '0;
      hitCnt   <= '0;
      hitsReg  <= '0;
      ownerReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (anyReq) begin
            ownerReg <= grantSel;
            shiftReg <= grantSel ? DATA1 : DATA0;
          end
        end
        CLEAR: begin
          hitCnt <= '0;
          bitCnt <= CNTW'(WIDTH - 1);
        end
        SHIFT: begin
          shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
          if (!lastBit)  bitCnt <= bitCnt - CNTW'(1);
          if (!firstBit) hitCnt <= hitCnt + CW'(Y);
        end
        // final sample folds straight into HITS so it is valid alongside DONE
        DRAIN: hitsReg <= hitCnt + CW'(Y);
        default: ;
      endcase
    end
  end

  assign GNT0      = gntActive & ~ownerReg;
  assign GNT1      = gntActive & ownerReg;
  assign X         = xOut;
  assign DET_RESET = RESET & ~clearPhase;
  assign DONE      = doneOut;
  assign HITS      = hitsReg;
  assign OWNER     = ownerReg;

endmodule

// File: tb/tb_detector_arbiter_ctrl.sv
// tb_detector_arbiter_ctrl
//   Detector stub: Y follows X one edge later and is cleared while DET_RESET is low,
//   so HITS must equal the popcount of the granted word.
module tb_detector_arbiter_ctrl;

  localparam int W = 8;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       REQ0 = 1'b0, REQ1 = 1'b0;
  logic [7:0] DATA0 = 8'h00, DATA1 = 8'h00;
  logic       Y;
  logic       GNT0, GNT1, X, DET_RESET, DONE, OWNER;
  logic [3:0] HITS;

  int total = 0;
  int bad   = 0;
  bit checkEn = 1'b0;

  detector_arbiter_ctrl #(.WIDTH(W), .CW(4)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1),
    .DATA0(DATA0), .DATA1(DATA1), .Y(Y),
    .GNT0(GNT0), .GNT1(GNT1), .X(X), .DET_RESET(DET_RESET),
    .DONE(DONE), .HITS(HITS), .OWNER(OWNER)
  );

  always #5 CLOCK = ~CLOCK;

  // detector stub
  always_ff @(posedge CLOCK or negedge DET_RESET) begin
    if (!DET_RESET) Y <= 1'b0;
    else            Y <= X;
  end

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: a frame is a timeline of offsets after the grant edge.
  // offset 0 clear, 1..W bits MSB-first, W+1 drain, W+2 report; -1 means idle.
  int         phase  = -1;
  logic [7:0] mWord  = 8'h00;
  logic       mOwner = 1'b0;
  logic [3:0] mHits  = 4'h0;

  always @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      phase  = -1;
      mOwner = 1'b0;
      mHits  = 4'h0;
    end else if (phase < 0) begin
      if (REQ0 || REQ1) begin
        if (REQ0 && REQ1) begin
`ifdef RR_ARB_EN
          mOwner = !mOwner;
`else
          mOwner = 1'b0;
`endif
        end else begin
          mOwner = REQ1;
        end
        mWord = mOwner ? DATA1 : DATA0;
        phase = 0;
      end
    end else if (phase == W + 2) begin
      phase = -1;
    end else begin
      phase = phase + 1;
      if (phase == W + 2) mHits = 4'($countones(mWord));
    end
  end

  // per-cycle comparison against the model
  always @(negedge CLOCK) begin
    if (checkEn) begin
      logic expX;
      expX = (phase >= 1 && phase <= W) ? mWord[W - phase] : 1'b0;
      chk("gnt0",     GNT0,      (phase >= 0) && !mOwner);
      chk("gnt1",     GNT1,      (phase >= 0) && mOwner);
      chk("x",        X,         expX);
      chk("detReset", DET_RESET, RESET && (phase != 0));
      chk("done",     DONE,      phase == W + 2);
      chk("hits",     HITS,      mHits);
      chk("owner",    OWNER,     mOwner);
    end
  end

  // Drives one frame request and reports what the DUT did. Called either from idle
  // or from the DONE cycle of a previous frame.
  task automatic runFrame(input logic r0, input logic r1, input logic [7:0] d0,
                          input logic [7:0] d1, input bit dropReq,
                          output logic gOwner, output logic [3:0] gHits,
                          output int lat, output logic [7:0] xs);
    int n;
    REQ0 = r0; REQ1 = r1; DATA0 = d0; DATA1 = d1;
    gOwner = 1'b0; gHits = 4'h0; lat = 0; xs = 8'h00;
    n = 0;
    while ((GNT0 || GNT1) && n < 30) begin @(negedge CLOCK); n++; end
    while (!(GNT0 || GNT1) && n < 30) begin @(negedge CLOCK); n++; end
    if (n >= 30) begin
      total++; bad++;
      $display("FAIL grantWait actual=nogrant required=grant at t=%0t", $time);
      return;
    end
    gOwner = OWNER;
    if (dropReq) begin
      REQ0 = 1'b0; REQ1 = 1'b0; DATA0 = 8'h00; DATA1 = 8'h00;
    end
    while (!DONE && lat < 30) begin
      @(negedge CLOCK);
      lat++;
      if (lat >= 1 && lat <= W) xs = {xs[6:0], X};
    end
    if (!DONE) begin
      total++; bad++;
      $display("FAIL doneWait actual=nodone required=done at t=%0t", $time);
    end
    gHits = HITS;
  endtask

  initial begin
    logic       o;
    logic [3:0] h;
    logic [7:0] xs;
    int         lat;
    int         n;

    // reset: low for 1ns
    #1 RESET = 1'b0;
    #1;
    chk("rstGnt0", GNT0, 1'b0);
    chk("rstGnt1", GNT1, 1'b0);
    chk("rstX", X, 1'b0);
    chk("rstHits", HITS, 4'h0);
    chk("rstDetResetLow", DET_RESET, 1'b0);
    RESET = 1'b1;
    #1;
    chk("rstDetResetHigh", DET_RESET, 1'b1);
    checkEn = 1'b1;
    repeat (2) @(negedge CLOCK);

    // single frame from requester 0; DONE comes W+2 cycles after the first
    // granted cycle, i.e. W+3 cycles counting the IDLE cycle REQ was seen in
    runFrame(1'b1, 1'b0, 8'b1011_0010, 8'h00, 1'b0, o, h, lat, xs);
    chk("f0Owner", o, 1'b0);
    chk("f0Xseq", xs, 8'b1011_0010);
    chk("f0Latency", lat, 10);
    chk("f0Hits", h, 4'd4);

    runFrame(1'b0, 1'b1, 8'h00, 8'hFF, 1'b0, o, h, lat, xs);
    chk("f1Owner", o, 1'b1);
    chk("f1Hits", h, 4'd8);
    runFrame(1'b0, 1'b1, 8'h00, 8'h00, 1'b0, o, h, lat, xs);
    chk("f1zOwner", o, 1'b1);
    chk("f1zHits", h, 4'd0);

    // both requesters held
    for (int k = 0; k < 4; k++) begin
      runFrame(1'b1, 1'b1, 8'h0F, 8'h01, 1'b0, o, h, lat, xs);
`ifdef RR_ARB_EN
      chk("tieOwner", o, (k % 2 == 1));
      chk("tieHits", h, (k % 2 == 1) ? 4'd1 : 4'd4);
`else
      chk("tieOwner", o, 1'b0);
      chk("tieHits", h, 4'd4);
`endif
    end

    // reset in SHIFT cycle 4
    REQ0 = 1'b1; REQ1 = 1'b0; DATA0 = 8'hFF;
    n = 0;
    while ((GNT0 || GNT1) && n < 30) begin @(negedge CLOCK); n++; end
    while (!GNT0 && n < 30) begin @(negedge CLOCK); n++; end
    repeat (4) @(negedge CLOCK);
    chk("preRstX", X, 1'b1);
    #2 RESET = 1'b0;
    #1;
    chk("midRstGnt0", GNT0, 1'b0);
    chk("midRstX", X, 1'b0);
    chk("midRstHits", HITS, 4'h0);
    chk("midRstDone", DONE, 1'b0);
    chk("midRstDetReset", DET_RESET, 1'b0);
    #1 RESET = 1'b1;
    runFrame(1'b1, 1'b0, 8'hFF, 8'h00, 1'b0, o, h, lat, xs);
    chk("postRstOwner", o, 1'b0);
    chk("postRstHits", h, 4'd8);

    // request dropped and data changed after capture
    runFrame(1'b1, 1'b0, 8'hE7, 8'h00, 1'b1, o, h, lat, xs);
    chk("dropOwner", o, 1'b0);
    chk("dropHits", h, 4'd6);
    chk("dropXseq", xs, 8'hE7);

    // randomized traffic with occasional asynchronous resets
    REQ0 = 1'b0; REQ1 = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge CLOCK);
      REQ0  = ($urandom_range(0, 3) == 0);
      REQ1  = ($urandom_range(0, 3) == 0);
      DATA0 = 8'($urandom);
      DATA1 = 8'($urandom);
      if ($urandom_range(0, 299) == 0) begin
        #1 RESET = 1'b0;
        #2 RESET = 1'b1;
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0;
    repeat (20) @(negedge CLOCK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
